score_display_mux: RTL and testbench

//  Consumer end of the BCD score counters. Takes both players' two-digit BCD scores and

---
 rtl/score_display_mux.sv | 194 +++++++++++++++++++
 tb/tb_score_display_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// score_display_mux: time-multiplexes two players' two-digit BCD scores onto a
// 4-digit common-anode 7-segment display (left to right: P1 tens, P1 ones,
// P2 tens, P2 ones). All outputs are registered.
// Optional build macro SCORE_FLASH_EN: blinks a player's digits after a score change.
module score_display_mux #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned GUARD_CYC  = 16,
  parameter int unsigned FLASH_DIV  = 25000000,
  parameter int unsigned FLASH_TOGS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       blank_lz,
  input  logic       dp_sep,
  input  logic [3:0] p1_dig1,
  input  logic [3:0] p1_dig0,
  input  logic [3:0] p2_dig1,
  input  logic [3:0] p2_dig0,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Reject configurations where a slot has no visible window or the blink timing is degenerate.
  if (SCAN_DIV < GUARD_CYC + 2 || FLASH_DIV < 1 || FLASH_TOGS < 1) begin : g_bad_cfg
    $error("score_display_mux: invalid parameter combination");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       sel_dig;
  logic             guard;
  logic             lz_blank;
  logic             flash_blank;

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

  // Active-low glyphs, seg[0]=a .. seg[6]=g; non-BCD values show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // Digit feeding the current slot.
  always_comb begin
    case (idx_q)
      2'd0:    sel_dig = p2_dig0;
      2'd1:    sel_dig = p2_dig1;
      2'd2:    sel_dig = p1_dig0;
      default: sel_dig = p1_dig1;
    endcase
  end

  // Scan counter, slot index and per-slot digit capture.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (cnt_q == '0) shadow_d = sel_dig;
    end
  end

`ifdef SCORE_FLASH_EN
  localparam int unsigned TOG_W  = $clog2(FLASH_TOGS + 1);
  localparam int unsigned FDIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  // Index 0 = player 1, index 1 = player 2.
  logic [1:0][7:0]        cur;
  logic [1:0][7:0]        prev_q, prev_d;
  logic [1:0][TOG_W-1:0]  fcnt_q, fcnt_d;
  logic [1:0][FDIV_W-1:0] fdiv_q, fdiv_d;
  logic [1:0]             phase_q, phase_d;
  logic [1:0]             flash_dark;

  assign cur[0] = {p1_dig1, p1_dig0};
  assign cur[1] = {p2_dig1, p2_dig0};

  // Per-player change detect and blink sequencing; a change restarts the sequence dark.
  always_comb begin
    prev_d     = cur;
    fcnt_d     = fcnt_q;
    fdiv_d     = fdiv_q;
    phase_d    = phase_q;
    flash_dark = '0;
    for (int p = 0; p < 2; p++) begin
      flash_dark[p] = (fcnt_q[p] != '0) && !phase_q[p];
      if (!en) begin
        fcnt_d[p]  = '0;
        fdiv_d[p]  = '0;
        phase_d[p] = 1'b0;
      end else if (cur[p] != prev_q[p]) begin
        fcnt_d[p]  = TOG_W'(FLASH_TOGS);
        fdiv_d[p]  = '0;
        phase_d[p] = 1'b0;
      end else if (fcnt_q[p] != '0) begin
        if (fdiv_q[p] == FDIV_W'(FLASH_DIV - 1)) begin
          fdiv_d[p]  = '0;
          phase_d[p] = ~phase_q[p];
          fcnt_d[p]  = fcnt_q[p] - TOG_W'(1);
        end else begin
          fdiv_d[p] = fdiv_q[p] + FDIV_W'(1);
        end
      end
    end
  end

  // Flash state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      fcnt_q  <= '0;
      fdiv_q  <= '0;
      phase_q <= '0;
    end else begin
      prev_q  <= prev_d;
      fcnt_q  <= fcnt_d;
      fdiv_q  <= fdiv_d;
      phase_q <= phase_d;
    end
  end

  // Slots 2/3 belong to player 1, slots 0/1 to player 2.
  assign flash_blank = idx_q[1] ? flash_dark[0] : flash_dark[1];
`else
  assign flash_blank = 1'b0;
`endif

  assign guard    = (cnt_q < CNT_W'(GUARD_CYC));
  assign lz_blank = blank_lz && idx_q[0] && (shadow_d == 4'd0);

  // Next display outputs; shadow_d is used so the capture cycle already sees the new digit.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && !guard) begin
      if (!lz_blank && !flash_blank) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = decode(shadow_d);
      end
      if (idx_q == 2'd2 && dp_sep) dp_d = 1'b0;
    end
  end

  // Scan and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Directed self-checking bench for score_display_mux (SCAN_DIV=8, GUARD_CYC=2,
// FLASH_DIV=4, FLASH_TOGS=2). Expected glyph/anode values are hand-entered per slot.
module tb_score_display_mux;
  logic       clk = 1'b0;
  logic       reset, en, blank_lz, dp_sep;
  logic [3:0] p1_dig1, p1_dig0, p2_dig1, p2_dig0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_display_mux #(.SCAN_DIV(8), .GUARD_CYC(2), .FLASH_DIV(4), .FLASH_TOGS(2)) dut (
    .clk(clk), .reset(reset), .en(en), .blank_lz(blank_lz), .dp_sep(dp_sep),
    .p1_dig1(p1_dig1), .p1_dig0(p1_dig0), .p2_dig1(p2_dig1), .p2_dig0(p2_dig0),
    .an(an), .seg(seg), .dp(dp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset 3 cycles and release just after an edge; the next step() is cycle k=1.
  task automatic start_scan();
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] ea[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h12, 7'h40, 7'h24, 7'h79};
    reset = 1'b0; en = 1'b1; blank_lz = 1'b0; dp_sep = 1'b0;
    p1_dig1 = 4'd1; p1_dig0 = 4'd2; p2_dig1 = 4'd0; p2_dig0 = 4'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", i, an, seg, dp);
      end
    end
    reset = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs;
      step();
      slot = (k - 1) / 8; c = (k - 1) % 8;
      xa = (c < 2) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      tests++;
      if (an !== xa || seg !== xs || dp !== 1'b1) begin
        fails++;
        $display("FAIL scan k=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", k, an, seg, dp, xa, xs);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [3:0] ea[4] = '{4'hE, 4'hF, 4'hB, 4'hF};
    logic [6:0] es[4] = '{7'h40, 7'h7F, 7'h78, 7'h7F};
    logic       care[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    blank_lz = 1'b1; dp_sep = 1'b0;
    p1_dig1 = 4'd0; p1_dig0 = 4'd7; p2_dig1 = 4'd0; p2_dig0 = 4'd0;
    start_scan();
    for (int k = 1; k <= 32; k++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs; logic sc;
      step();
      slot = (k - 1) / 8; c = (k - 1) % 8;
      xa = (c < 2) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      sc = (c < 2) ? 1'b1 : care[slot];
      tests++;
      if (an !== xa || (sc && seg !== xs) || dp !== 1'b1) begin
        fails++;
        $display("FAIL blank_lz k=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", k, an, seg, dp, xa, xs);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_glitch_dash();
    logic [3:0] ea[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h3F, 7'h40, 7'h30, 7'h40};
    p1_dig1 = 4'd0; p1_dig0 = 4'd3; p2_dig1 = 4'd0; p2_dig0 = 4'hB;
    start_scan();
    for (int k = 1; k <= 32; k++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs;
      step();
      slot = (k - 1) / 8; c = (k - 1) % 8;
      xa = (c < 2) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      tests++;
      if (an !== xa || seg !== xs || dp !== 1'b1) begin
        fails++;
        $display("FAIL glitch_dash k=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", k, an, seg, dp, xa, xs);
      end
      if (k == 19) p1_dig0 = 4'd4;
      if (k == 20) p1_dig0 = 4'd3;
    end
  endtask

  task automatic test_dp_en();
    logic [3:0] ea[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h12, 7'h40, 7'h24, 7'h79};
    dp_sep = 1'b1;
    p1_dig1 = 4'd1; p1_dig0 = 4'd2; p2_dig1 = 4'd0; p2_dig0 = 4'd5;
    start_scan();
    for (int k = 1; k <= 44; k++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs; logic xd;
      step();
      slot = ((k - 1) / 8) % 4; c = (k - 1) % 8;
      xa = (c < 2) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      xd = (slot == 2 && c >= 2) ? 1'b0 : 1'b1;
      tests++;
      if (an !== xa || seg !== xs || dp !== xd) begin
        fails++;
        $display("FAIL dp_sep k=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b", k, an, seg, dp, xa, xs, xd);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        fails++;
        $display("FAIL en_low cyc %0d: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", i, an, seg, dp);
      end
    end
    en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs;
      step();
      slot = (j - 1) / 8; c = (j - 1) % 8;
      xa = (c < 2) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      tests++;
      if (an !== xa || seg !== xs || dp !== 1'b1) begin
        fails++;
        $display("FAIL en_restart j=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", j, an, seg, dp, xa, xs);
      end
    end
    dp_sep = 1'b0;
  endtask

  task automatic test_reset_mid();
    p1_dig1 = 4'd1; p1_dig0 = 4'd2; p2_dig1 = 4'd0; p2_dig0 = 4'd5;
    start_scan();
    repeat (20) step();
    tests++;
    if (an !== 4'hB || seg !== 7'h24) begin
      fails++;
      $display("FAIL pre_reset_slot2: an=%h seg=%h, want an=B seg=24", an, seg);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_async: an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an, seg, dp);
    end
    step(); step();
    reset = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      logic [3:0] xa; logic [6:0] xs;
      step();
      xa = (j == 1 || j == 2 || j == 9 || j == 10) ? 4'hF : 4'hE;
      xs = (xa == 4'hF) ? 7'h7F : 7'h12;
      tests++;
      if (an !== xa || seg !== xs) begin
        fails++;
        $display("FAIL reset_restart j=%0d: an=%h seg=%h, want an=%h seg=%h", j, an, seg, xa, xs);
      end
    end
  endtask

  // Score changes mid-scan; with SCORE_FLASH_EN the changed players blink.
  task automatic test_score_change();
    logic [3:0] ea[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] es[4] = '{7'h79, 7'h40, 7'h19, 7'h40};
    p1_dig1 = 4'd0; p1_dig0 = 4'd3; p2_dig1 = 4'd0; p2_dig0 = 4'd0;
    start_scan();
    for (int k = 1; k <= 40; k++) begin
      int slot, c;
      logic [3:0] xa; logic [6:0] xs; logic dark;
      step();
      slot = ((k - 1) / 8) % 4; c = (k - 1) % 8;
`ifdef SCORE_FLASH_EN
      dark = (k >= 12 && k <= 15) || (k >= 20 && k <= 23);
`else
      dark = 1'b0;
`endif
      xa = (c < 2 || dark) ? 4'hF : ea[slot];
      xs = (c < 2) ? 7'h7F : es[slot];
      if (k >= 11) begin
        tests++;
        if (an !== xa || (!dark && seg !== xs) || dp !== 1'b1) begin
          fails++;
          $display("FAIL score_change k=%0d: an=%h seg=%h dp=%b, want an=%h seg=%h dp=1", k, an, seg, dp, xa, xs);
        end
      end
      if (k == 10) begin
        p1_dig0 = 4'd4;
        p2_dig0 = 4'd1;
      end
      if (k == 18) p1_dig0 = 4'd5;
    end
  endtask

  initial begin
    test_reset();
    test_blank_lz();
    test_glitch_dash();
    test_dp_en();
    test_reset_mid();
    test_score_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
